// File: rtl/invader_grid_if.sv
// Video-position, control and status bundle between the VGA timing/game logic
// and the invader formation block.
`timescale 1ns/1ps
interface invader_grid_if;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic       start;
  logic       kill_valid;
  logic [1:0] kill_row;
  logic [2:0] kill_col;
  logic       pixel_on;
  logic       frame_tick;
  logic [9:0] formation_x;
  logic [9:0] formation_y;
  logic [5:0] alive_count;
  logic       all_dead;
  logic       landed;

  modport master (
    output hpos, vpos, display_on, start, kill_valid, kill_row, kill_col,
    input  pixel_on, frame_tick, formation_x, formation_y, alive_count,
           all_dead, landed
  );

  modport slave (
    input  hpos, vpos, display_on, start, kill_valid, kill_row, kill_col,
    output pixel_on, frame_tick, formation_x, formation_y, alive_count,
           all_dead, landed
  );
endinterface

// File: rtl/invader_grid.sv
// 4x8 alien formation: marches once per step period during vblank, takes kill
// requests, and renders a registered per-pixel alien mask.
`timescale 1ns/1ps
module invader_grid #(
  parameter int START_X      = 64,
  parameter int START_Y      = 48,
  parameter int STEP_X       = 4,
  parameter int STEP_Y       = 8,
  parameter int LEFT_LIMIT   = 8,
  parameter int RIGHT_LIMIT  = 632,
  parameter int BOTTOM_LIMIT = 440
) (
  input  logic           clk,
  input  logic           rst_n,
  invader_grid_if.slave  bus
);
  localparam int ROWS = 4;
  localparam int COLS = 8;
  localparam logic [63:0] FRAME_A = 64'h183C_7EDB_FF24_5AA5;
  localparam logic [63:0] FRAME_B = 64'h183C_7EDB_FF5A_8142;

  localparam logic [1:0] S_WAIT    = 2'd0;
  localparam logic [1:0] S_MOVE    = 2'd1;
  localparam logic [1:0] S_CLEARED = 2'd2;
  localparam logic [1:0] S_LANDED  = 2'd3;

  localparam logic [9:0]  P_X0  = 10'(START_X);
  localparam logic [9:0]  P_Y0  = 10'(START_Y);
  localparam logic [9:0]  P_SX  = 10'(STEP_X);
  localparam logic [9:0]  P_SY  = 10'(STEP_Y);
  localparam logic [10:0] P_SXW = 11'(STEP_X);
  localparam logic [10:0] P_LL  = 11'(LEFT_LIMIT);
  localparam logic [10:0] P_RL  = 11'(RIGHT_LIMIT);
  localparam logic [10:0] P_BL  = 11'(BOTTOM_LIMIT);

  logic [31:0] r_alive;
  logic [5:0]  r_count;
  logic [5:0]  r_frame_cnt;
  logic [1:0]  r_state;
  logic [9:0]  r_x, r_y;
  logic        r_dir, r_anim, r_tick, r_pixel;

  // Formation extents over live aliens
  logic [7:0] w_col_any;
  logic [3:0] w_row_any;
  logic [2:0] w_lc, w_rc;
  logic [1:0] w_br;

  always_comb begin
    w_col_any = '0;
    w_row_any = '0;
    w_lc = '0;
    w_rc = '0;
    w_br = '0;
    for (int c = 0; c < COLS; c++)
      w_col_any[c] = r_alive[c] | r_alive[8+c] | r_alive[16+c] | r_alive[24+c];
    for (int r = 0; r < ROWS; r++)
      w_row_any[r] = |r_alive[r*8 +: 8];
    for (int c = COLS-1; c >= 0; c--)
      if (w_col_any[c]) w_lc = 3'(c);
    for (int c = 0; c < COLS; c++)
      if (w_col_any[c]) w_rc = 3'(c);
    for (int r = 0; r < ROWS; r++)
      if (w_row_any[r]) w_br = 2'(r);
  end

  // March step: bound checks in 11 bits so nothing wraps near the screen edge
  logic [10:0] w_redge, w_ledge, w_bot;
  logic        w_desc, w_land;
  logic [9:0]  w_nx, w_ny;

  assign w_redge = {1'b0, r_x} + {3'b0, w_rc, 5'b0} + 11'd16 + P_SXW;
  assign w_ledge = {1'b0, r_x} + {3'b0, w_lc, 5'b0};
  assign w_desc  = r_dir ? (w_ledge < P_LL + P_SXW) : (w_redge > P_RL);
  assign w_ny    = w_desc ? r_y + P_SY : r_y;
  assign w_nx    = w_desc ? r_x : (r_dir ? r_x - P_SX : r_x + P_SX);
  assign w_bot   = {1'b0, w_ny} + {4'b0, w_br, 5'b0} + 11'd16;
  assign w_land  = w_bot >= P_BL;

  logic [6:0] w_period, w_cnt_nx;
  assign w_period = 7'd1 + {2'b0, r_count[5:1]};
  assign w_cnt_nx = {1'b0, r_frame_cnt} + 7'd1;

  logic [4:0] w_kidx;
  logic       w_kill;
  assign w_kidx = {bus.kill_row, bus.kill_col};
  assign w_kill = bus.kill_valid && r_alive[w_kidx];

  // Renderer works on half-resolution offsets: bit 0 of dx/dy is the x2 scale
  logic [8:0] w_dxh, w_dyh;
  logic [4:0] w_idx;
  logic [63:0] w_bmp;
  logic [7:0] w_bits;
  logic       w_in, w_hit;

  assign w_dxh  = 9'((bus.hpos - r_x) >> 1);
  assign w_dyh  = 9'((bus.vpos - r_y) >> 1);
  assign w_in   = (bus.hpos >= r_x) && (bus.vpos >= r_y) &&
                  (w_dxh[8:7] == 2'b0) && !w_dxh[3] &&
                  (w_dyh[8:6] == 3'b0) && !w_dyh[3];
  assign w_idx  = {w_dyh[5:4], w_dxh[6:4]};
  assign w_bmp  = r_anim ? FRAME_B : FRAME_A;
  assign w_bits = w_bmp[{~w_dyh[2:0], 3'b000} +: 8];
  assign w_hit  = w_in && r_alive[w_idx] && w_bits[~w_dxh[2:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alive     <= '1;
      r_count     <= 6'd32;
      r_frame_cnt <= '0;
      r_state     <= S_WAIT;
      r_x         <= P_X0;
      r_y         <= P_Y0;
      r_dir       <= 1'b0;
      r_anim      <= 1'b0;
      r_tick      <= 1'b0;
      r_pixel     <= 1'b0;
    end else if (bus.start) begin
      r_alive     <= '1;
      r_count     <= 6'd32;
      r_frame_cnt <= '0;
      r_state     <= S_WAIT;
      r_x         <= P_X0;
      r_y         <= P_Y0;
      r_dir       <= 1'b0;
      r_anim      <= 1'b0;
      r_tick      <= 1'b0;
      r_pixel     <= 1'b0;
    end else begin
      r_tick  <= (bus.hpos == 10'd0) && (bus.vpos == 10'd480);
      r_pixel <= w_hit && bus.display_on;
      case (r_state)
        S_WAIT: if (r_tick) begin
          if (w_cnt_nx >= w_period) begin
            r_frame_cnt <= '0;
            r_state     <= S_MOVE;
          end else begin
            r_frame_cnt <= w_cnt_nx[5:0];
          end
        end
        S_MOVE: begin
          r_x     <= w_nx;
          r_y     <= w_ny;
          r_anim  <= ~r_anim;
          if (w_desc) r_dir <= ~r_dir;
          r_state <= w_land ? S_LANDED : S_WAIT;
        end
        default: ;
      endcase
      // Last kill overrides whatever the march decided this cycle
      if (w_kill) begin
        r_alive[w_kidx] <= 1'b0;
        r_count         <= r_count - 6'd1;
        if (r_count == 6'd1 && (r_state == S_WAIT || r_state == S_MOVE))
          r_state <= S_CLEARED;
      end
    end
  end

  assign bus.pixel_on    = r_pixel;
  assign bus.frame_tick  = r_tick;
  assign bus.formation_x = r_x;
  assign bus.formation_y = r_y;
  assign bus.alive_count = r_count;
  assign bus.all_dead    = (r_state == S_CLEARED);
  assign bus.landed      = (r_state == S_LANDED);
endmodule

// File: tb/tb_invader_grid.sv
// Directed bench for invader_grid: rendering, march timing, wall turn, kills,
// landing, clear-on-move and asynchronous reset.
`timescale 1ns/1ps
module tb_invader_grid;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  always #20 clk = ~clk;

  invader_grid_if bus();
  invader_grid dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.hpos = 10'd700; bus.vpos = 10'd500; bus.display_on = 1'b0;
  endtask

  task automatic pix(input string tag, input int h, input int v, input bit de, input bit exp);
    @(negedge clk);
    bus.hpos = 10'(h); bus.vpos = 10'(v); bus.display_on = de;
    @(negedge clk);
    chk(tag, bus.pixel_on, exp);
    idle();
  endtask

  // One frame boundary, then enough cycles for WAIT->MOVE->update to settle
  task automatic frame();
    @(negedge clk);
    bus.hpos = 10'd0; bus.vpos = 10'd480; bus.display_on = 1'b0;
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
  endtask

  task automatic kill(input int idx);
    @(negedge clk);
    bus.kill_valid = 1'b1; bus.kill_row = 2'(idx / 8); bus.kill_col = 3'(idx % 8);
    @(negedge clk);
    bus.kill_valid = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    idle();
    bus.start = 1'b0; bus.kill_valid = 1'b0; bus.kill_row = '0; bus.kill_col = '0;
    #110 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_x", bus.formation_x, 64);
    chk("rst_y", bus.formation_y, 48);
    chk("rst_count", bus.alive_count, 32);
    chk("rst_dead", bus.all_dead, 0);
    chk("rst_landed", bus.landed, 0);
    chk("rst_pix", bus.pixel_on, 0);
    chk("rst_tick", bus.frame_tick, 0);

    pix("pix_70_48", 70, 48, 1, 1);
    pix("pix_64_48", 64, 48, 1, 0);
    pix("pix_gap_80", 80, 48, 1, 0);
    pix("pix_blank", 70, 48, 0, 0);
    pix("pix_frameA_66_58", 66, 58, 1, 0);

    // First frame tick, exactly one cycle wide
    @(negedge clk); bus.hpos = 10'd0; bus.vpos = 10'd480;
    @(negedge clk); chk("tick_hi", bus.frame_tick, 1); idle();
    @(negedge clk); chk("tick_lo", bus.frame_tick, 0);

    repeat (15) frame();
    chk("x_after16", bus.formation_x, 64);
    frame();
    chk("x_after17", bus.formation_x, 68);
    chk("y_after17", bus.formation_y, 48);
    pix("pix_frameB_70_58", 70, 58, 1, 1);
    pix("pix_frameB_70_48", 70, 48, 1, 0);

    pix("pix_pre_kill", 74, 48, 1, 1);
    kill(0);
    chk("kill_count", bus.alive_count, 31);
    pix("pix_post_kill", 74, 48, 1, 0);
    kill(0);
    chk("rekill_count", bus.alive_count, 31);

    for (int i = 1; i < 32; i++) if (i != 7) kill(i);
    chk("one_left", bus.alive_count, 1);
    repeat (81) frame();
    chk("wall_x", bus.formation_x, 392);
    chk("wall_y", bus.formation_y, 48);
    frame();
    chk("desc_x", bus.formation_x, 392);
    chk("desc_y", bus.formation_y, 56);
    frame();
    chk("left_x", bus.formation_x, 388);
    chk("left_y", bus.formation_y, 56);

    do_start();
    chk("start_x", bus.formation_x, 64);
    chk("start_count", bus.alive_count, 32);
    for (int i = 0; i < 32; i++) if (i != 24) kill(i);
    chk("row3_count", bus.alive_count, 1);
    chk("pre_land", bus.landed, 0);
    begin
      int n = 0;
      while (!bus.landed && n < 6000) begin
        frame();
        n++;
      end
    end
    chk("landed", bus.landed, 1);
    chk("land_y", bus.formation_y, 328);
    chk("land_x", bus.formation_x, 616);
    repeat (3) frame();
    chk("frozen_x", bus.formation_x, 616);
    chk("frozen_y", bus.formation_y, 328);
    kill(24);
    chk("landed_stays", bus.landed, 1);

    do_start();
    chk("restart_x", bus.formation_x, 64);
    chk("restart_y", bus.formation_y, 48);
    chk("restart_count", bus.alive_count, 32);
    chk("restart_landed", bus.landed, 0);

    // Last kill lands on the MOVE cycle
    for (int i = 1; i < 32; i++) kill(i);
    @(negedge clk); bus.hpos = 10'd0; bus.vpos = 10'd480;
    @(negedge clk); idle();
    @(negedge clk); bus.kill_valid = 1'b1; bus.kill_row = 2'd0; bus.kill_col = 3'd0;
    @(negedge clk); bus.kill_valid = 1'b0;
    chk("clr_x", bus.formation_x, 68);
    chk("clr_dead", bus.all_dead, 1);
    chk("clr_count", bus.alive_count, 0);
    frame();
    chk("clr_frozen_x", bus.formation_x, 68);

    @(negedge clk);
    bus.hpos = 10'd100; bus.vpos = 10'd50; bus.display_on = 1'b1;
    #5 rst_n = 1'b0;
    #1;
    chk("arst_x", bus.formation_x, 64);
    chk("arst_y", bus.formation_y, 48);
    chk("arst_count", bus.alive_count, 32);
    chk("arst_dead", bus.all_dead, 0);
    chk("arst_landed", bus.landed, 0);
    chk("arst_pix", bus.pixel_on, 0);
    chk("arst_tick", bus.frame_tick, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
